dds_tx_scheduler: RTL and testbench
===================================

Name: dds_tx_scheduler

Overview:
- Time-slot scheduler and arbiter for the beacon's single AD9850 DDS, which is shared by the Costas-array and PSK station-ID modes.
- Derives second, minute and ten-minute slots from the synchronised 1 PPS input and grants the DDS to one mode per slot.
- Generates the per-symbol MCU load strobe and the DDS fq_ud pulse, phase-locked to the 10 MHz reference, and reports missed or colliding slots.

Parameters:
- CLK_HZ, 10000000, reference clock frequency; sets the PPS watchdog limit.
- COSTAS_SYM_DIV, 1000000, clock cycles per Costas symbol (10 Hz symbol rate).
- PSK_SYM_DIV, 50000, clock cycles per PSK symbol (200 Hz symbol rate).
- COSTAS_LEN, 32, number of Costas symbols per transmission.
- PSK_MAX_SYM, 1024, maximum PSK symbols per transmission.
- FQ_UD_CYCLES, 4, fq_ud pulse width in clock cycles.
- GUARD_CYCLES, 10000, dead time after any transmission ends.

Ports:
- clk10M_w  in  1  10 MHz reference clock. Single clock domain.
- reset  in  1  asynchronous, active-high reset.
- pps  in  1  asynchronous 1 Hz pulse.
- time_sync  in  1  when high at a PPS edge, that second becomes second 0 of a ten-minute frame.
- costas_txrq  in  1  MCU has a Costas array loaded and wants to transmit.
- psk_txrq  in  1  MCU has a PSK ID message loaded and wants to transmit.
- grant_costas  out  1  DDS owned by Costas mode.
- grant_psk  out  1  DDS owned by PSK mode.
- sym_tick  out  1  1-cycle MCU strobe: load the next symbol word.
- fq_ud  out  1  DDS frequency-update strobe.
- sym_index  out  10  index of the symbol currently on air.
- sec_count  out  10  second within the ten-minute frame, 0..599.
- missed  out  1  1-cycle pulse: a slot was skipped.
- pps_lost  out  1  PPS watchdog flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- PPS handling:
  - pps passes through a 2-FF synchroniser, then rising-edge detection to produce pps_edge.
  - pps_edge is asserted 3 cycles after the pps rise.
- Second counter:
  - On pps_edge, sec_count increments and wraps 599→0.
  - If time_sync is high on pps_edge, sec_count loads 0 instead (takes precedence over increment).
- Slot decode, evaluated on the new sec_count value at pps_edge:
  - Value 0 is a PSK slot.
  - Any other multiple of 60 is a Costas slot.
  - At second 0, PSK has absolute priority; no Costas slot occurs.
- FSM states: IDLE, TX_C, TX_P, GUARD.
- IDLE:
  - On a Costas slot: go to TX_C if costas_txrq=1, otherwise pulse missed.
  - On a PSK slot: go to TX_P if psk_txrq=1, otherwise pulse missed.
  - No slot starts while pps_lost=1; pulse missed instead.
- TX entry (cycle S = cycle after pps_edge):
  - grant_x=1, sym_index=0, divider=0.
- TX_C / TX_P symbol timing:
  - Divider counts 0..DIV-1.
  - fq_ud is high while divider < FQ_UD_CYCLES.
  - sym_tick pulses when divider == DIV/2.
  - On divider wrap, sym_index increments.
- TX end conditions:
  - TX_C completes when the symbol with sym_index = COSTAS_LEN-1 wraps.
  - TX_P completes when psk_txrq=0 at a symbol wrap, or when the symbol with sym_index = PSK_MAX_SYM-1 wraps.
  - On completion, go to GUARD; no fq_ud is issued for the non-existent next symbol.
- Abort:
  - costas_txrq falling during TX_C aborts to GUARD immediately; fq_ud is forced to 0 that cycle.
  - psk_txrq falling mid-symbol is honoured only at the symbol wrap.
- GUARD:
  - grants=0, sym_index=0.
  - Lasts GUARD_CYCLES cycles, then returns to IDLE.
- Collision: a slot edge arriving in TX_x or GUARD pulses missed; the current operation continues unchanged.
- Watchdog:
  - Cycles since the last pps_edge are counted.
  - Reaching CLK_HZ + CLK_HZ/8 sets pps_lost; the next pps_edge clears it.
  - An ongoing TX is unaffected by pps_lost.
- Invariants:
  - grant_costas and grant_psk are never high together.
  - fq_ud and sym_tick are only high while a grant is high.
- Reset asserted mid-TX returns all outputs to 0 asynchronously. After release, nothing starts before the next valid slot edge.

Test Plan (reduced parameters: COSTAS_SYM_DIV=100, PSK_SYM_DIV=20, COSTAS_LEN=4, PSK_MAX_SYM=8, GUARD_CYCLES=10, CLK_HZ=1000):
- time_sync pulse, then 60 pps with costas_txrq=1:
  - grant_costas rises 4 cycles after the 60th pps rise.
  - Exactly 4 fq_ud pulses, each 4 cycles wide, spaced 100 cycles apart.
  - sym_tick pulses at offsets 50/150/250/350; then grant drops, GUARD runs 10 cycles, then IDLE.
- Advance to sec_count=0 with both requests high:
  - grant_psk only; 8 symbols; grant_costas never rises.
- Minute slot with costas_txrq=0:
  - Single-cycle missed pulse; grants stay 0.
- PSK running with psk_txrq dropped mid-symbol 3:
  - Ends at the symbol 3 wrap; sym_index max = 3; no further fq_ud.
- Withhold pps for 1200 cycles:
  - pps_lost=1 at cycle 1125; the next slot edge gives missed and no grant.
  - The following pps clears pps_lost.
- Assert reset in TX_C symbol 2:
  - All outputs 0 within the same cycle.
  - sec_count=0; no grant until the next qualifying slot.

Source files
------------

// File: rtl/dds_tx_scheduler_if.sv
// Bus bundle between the scheduler and the beacon logic around it.
// Signals:
//   pps, time_sync          : timing inputs (pps is asynchronous)
//   costas_txrq, psk_txrq   : per-mode transmit requests from the MCU
//   grant_costas, grant_psk : DDS ownership
//   sym_tick, fq_ud         : per-symbol MCU load strobe and DDS update strobe
//   sym_index, sec_count    : symbol on air, second within the ten-minute frame
//   missed, pps_lost        : skipped-slot pulse and PPS watchdog flag
//   fsm_state               : scheduler state (IDLE=0, TX_C=1, TX_P=2, GUARD=3)
// Modports: master drives the requests and PPS, slave is the scheduler.
interface dds_tx_scheduler_if;
    logic       pps;
    logic       time_sync;
    logic       costas_txrq;
    logic       psk_txrq;
    logic       grant_costas;
    logic       grant_psk;
    logic       sym_tick;
    logic       fq_ud;
    logic [9:0] sym_index;
    logic [9:0] sec_count;
    logic       missed;
    logic       pps_lost;
    logic [1:0] fsm_state;

    modport master (
        output pps, time_sync, costas_txrq, psk_txrq,
        input  grant_costas, grant_psk, sym_tick, fq_ud, sym_index,
               sec_count, missed, pps_lost, fsm_state
    );

    modport slave (
        input  pps, time_sync, costas_txrq, psk_txrq,
        output grant_costas, grant_psk, sym_tick, fq_ud, sym_index,
               sec_count, missed, pps_lost, fsm_state
    );
endinterface

// File: rtl/dds_tx_scheduler.sv
// Time-slot scheduler and arbiter for the beacon's single AD9850 DDS.
// The synchronised PPS advances a 0..599 second counter. Second 0 is the
// PSK station-ID slot, every other multiple of 60 is a Costas slot. In a
// granted slot the scheduler paces symbols from the reference clock: fq_ud
// is high for the first FQ_UD_CYCLES cycles of every symbol and sym_tick
// asks the MCU for the next word at mid-symbol. Every transmission ends in
// a GUARD dead time. Slots that cannot be served pulse missed.
//
// Handshake: there is no valid/ready pair. A request (costas_txrq /
// psk_txrq) is a level that must be high at the slot edge to win the slot
// and must stay high for the transmission to continue; the grant is the
// acknowledgement and stays high for the whole transmission.
//
// Ports:
//   clk10M_w : 10 MHz reference clock, single clock domain
//   reset    : asynchronous, active-high
//   bus      : dds_tx_scheduler_if.slave (see interface file)
module dds_tx_scheduler #(
    parameter int CLK_HZ         = 10000000,
    parameter int COSTAS_SYM_DIV = 1000000,
    parameter int PSK_SYM_DIV    = 50000,
    parameter int COSTAS_LEN     = 32,
    parameter int PSK_MAX_SYM    = 1024,
    parameter int FQ_UD_CYCLES   = 4,
    parameter int GUARD_CYCLES   = 10000
) (
    input  logic                clk10M_w,
    input  logic                reset,
    dds_tx_scheduler_if.slave   bus
);

    localparam int DIV_MAX  = (COSTAS_SYM_DIV > PSK_SYM_DIV) ? COSTAS_SYM_DIV : PSK_SYM_DIV;
    localparam int DW       = $clog2(DIV_MAX + 1);
    localparam int WD_LIMIT = CLK_HZ + CLK_HZ / 8;
    localparam int WW       = $clog2(WD_LIMIT + 1);
    localparam int GW       = $clog2(GUARD_CYCLES + 1);

    localparam logic [DW-1:0] C_LAST = DW'(COSTAS_SYM_DIV - 1);
    localparam logic [DW-1:0] C_HALF = DW'(COSTAS_SYM_DIV / 2);
    localparam logic [DW-1:0] P_LAST = DW'(PSK_SYM_DIV - 1);
    localparam logic [DW-1:0] P_HALF = DW'(PSK_SYM_DIV / 2);
    localparam logic [DW-1:0] FQ_N   = DW'(FQ_UD_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_LIMIT - 1);
    localparam logic [GW-1:0] G_LAST  = GW'(GUARD_CYCLES - 1);
    localparam logic [9:0]    C_SYM_LAST = 10'(COSTAS_LEN - 1);
    localparam logic [9:0]    P_SYM_LAST = 10'(PSK_MAX_SYM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TX_C  = 2'd1,
        TX_P  = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            missed_next;

    logic            pps_s1;
    logic            pps_s2;
    logic            pps_s3;
    logic            pps_edge;
    logic [9:0]      sec_count;
    logic [9:0]      sec_next;
    logic            slot_c;
    logic            slot_p;
    logic            slot_any;
    logic [WW-1:0]   wd_cnt;
    logic            pps_lost;
    logic [DW-1:0]   div;
    logic            div_wrap;
    logic [9:0]      sym_index;
    logic [GW-1:0]   guard_cnt;
    logic            missed;
    logic            in_tx;

    // Two synchroniser flops, a history flop for edge detection, and a
    // registered edge: pps_edge is high in the third cycle after the rise.
    always_ff @(posedge clk10M_w or posedge reset) begin
        if (reset) begin
            pps_s1   <= 1'b0;
            pps_s2   <= 1'b0;
            pps_s3   <= 1'b0;
            pps_edge <= 1'b0;
        end else begin
            pps_s1   <= bus.pps;
            pps_s2   <= pps_s1;
            pps_s3   <= pps_s2;
            pps_edge <= pps_s2 & ~pps_s3;
        end
    end

    // time_sync forces second 0 ahead of the normal increment/wrap.
    always_comb begin
        sec_next = sec_count + 10'd1;
        if (bus.time_sync || sec_count == 10'd599) begin
            sec_next = 10'd0;
        end
    end

    // Slots are decoded on the second being entered. Second 0 is PSK only.
    assign slot_p   = pps_edge && (sec_next == 10'd0);
    assign slot_c   = pps_edge && (sec_next != 10'd0) && ((sec_next % 10'd60) == 10'd0);
    assign slot_any = slot_p || slot_c;

    always_ff @(posedge clk10M_w or posedge reset) begin
        if (reset) begin
            sec_count <= 10'd0;
        end else if (pps_edge) begin
            sec_count <= sec_next;
        end
    end

    // Watchdog saturates at its limit so pps_lost stays set until a PPS.
    always_ff @(posedge clk10M_w or posedge reset) begin
        if (reset) begin
            wd_cnt   <= '0;
            pps_lost <= 1'b0;
        end else if (pps_edge) begin
            wd_cnt   <= '0;
            pps_lost <= 1'b0;
        end else if (wd_cnt == WD_LAST) begin
            pps_lost <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign in_tx    = (state == TX_C) || (state == TX_P);
    assign div_wrap = (state == TX_C) ? (div == C_LAST) : (div == P_LAST);

    always_ff @(posedge clk10M_w or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        missed_next = 1'b0;
        case (state)
            IDLE: begin
                if (slot_any) begin
                    if (pps_lost) begin
                        missed_next = 1'b1;
                    end else if (slot_p) begin
                        if (bus.psk_txrq) state_next = TX_P;
                        else              missed_next = 1'b1;
                    end else begin
                        if (bus.costas_txrq) state_next = TX_C;
                        else                 missed_next = 1'b1;
                    end
                end
            end
            TX_C: begin
                missed_next = slot_any;
                // A dropped Costas request aborts at once, not at the wrap.
                if (!bus.costas_txrq) begin
                    state_next = GUARD;
                end else if (div_wrap && sym_index == C_SYM_LAST) begin
                    state_next = GUARD;
                end
            end
            TX_P: begin
                missed_next = slot_any;
                if (div_wrap && (!bus.psk_txrq || sym_index == P_SYM_LAST)) begin
                    state_next = GUARD;
                end
            end
            GUARD: begin
                missed_next = slot_any;
                if (guard_cnt == G_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Divider and symbol index only run while staying in a TX state, so
    // they read 0 on TX entry and throughout GUARD.
    always_ff @(posedge clk10M_w or posedge reset) begin
        if (reset) begin
            div       <= '0;
            sym_index <= 10'd0;
            guard_cnt <= '0;
            missed    <= 1'b0;
        end else begin
            if (in_tx && state_next == state) begin
                if (div_wrap) begin
                    div       <= '0;
                    sym_index <= sym_index + 10'd1;
                end else begin
                    div <= div + 1'b1;
                end
            end else begin
                div       <= '0;
                sym_index <= 10'd0;
            end
            guard_cnt <= (state == GUARD) ? guard_cnt + 1'b1 : '0;
            missed    <= missed_next;
        end
    end

    assign bus.grant_costas = (state == TX_C);
    assign bus.grant_psk    = (state == TX_P);
    // fq_ud drops in the same cycle the Costas request is withdrawn.
    assign bus.fq_ud        = (((state == TX_C) && bus.costas_txrq) || (state == TX_P)) && (div < FQ_N);
    assign bus.sym_tick     = ((state == TX_C) && (div == C_HALF)) || ((state == TX_P) && (div == P_HALF));
    assign bus.sym_index    = sym_index;
    assign bus.sec_count    = sec_count;
    assign bus.missed       = missed;
    assign bus.pps_lost     = pps_lost;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_dds_tx_scheduler.sv
// Bench for dds_tx_scheduler with reduced timing parameters.
// Expected output pulses are pushed as {kind, rise cycle, width, index}
// when a PPS is issued; a negedge monitor turns every completed pulse of
// the DUT outputs into the same word and compares it with the queue head.
module tb_dds_tx_scheduler;

    localparam int W = 48;
    localparam logic [1:0] ST_GUARD = 2'd3;

    // Event kinds
    localparam int EV_MISSED = 0;
    localparam int EV_LOST   = 1;
    localparam int EV_GC     = 2;
    localparam int EV_GP     = 3;
    localparam int EV_FQ     = 4;
    localparam int EV_TICK   = 5;
    localparam int EV_GUARD  = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dds_tx_scheduler_if bus();

    dds_tx_scheduler #(
        .CLK_HZ         (1000),
        .COSTAS_SYM_DIV (100),
        .PSK_SYM_DIV    (20),
        .COSTAS_LEN     (4),
        .PSK_MAX_SYM    (8),
        .FQ_UD_CYCLES   (4),
        .GUARD_CYCLES   (10)
    ) dut (
        .clk10M_w (clk),
        .reset    (rst),
        .bus      (bus)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    function automatic string ev_name(input int k);
        case (k)
            EV_MISSED: return "missed";
            EV_LOST:   return "pps_lost";
            EV_GC:     return "grant_costas";
            EV_GP:     return "grant_psk";
            EV_FQ:     return "fq_ud";
            EV_TICK:   return "sym_tick";
            default:   return "guard";
        endcase
    endfunction

    task automatic exp_ev(input int kind, input int rise, input int width, input int idx);
        exp_q.push_back({4'(kind), 20'(rise), 16'(width), 8'(idx)});
    endtask

    task automatic check_ev(input int kind, input int rise, input int width, input int idx);
        logic [W-1:0] got;
        logic [W-1:0] want;
        got = {4'(kind), 20'(rise), 16'(width), 8'(idx)};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL ev_%s: got rise=%0d width=%0d idx=%0d, required no event",
                     ev_name(kind), rise, width, idx);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_mis++;
                $display("FAIL ev_%s: got rise=%0d width=%0d idx=%0d, required %s rise=%0d width=%0d idx=%0d",
                         ev_name(kind), rise, width, idx, ev_name(int'(want[47:44])),
                         want[43:24], want[23:8], want[7:0]);
            end
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_mis++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    logic [6:0] prv = '0;
    int rise_c[7];
    int rise_i[7];

    always @(negedge clk) begin : mon
        logic [6:0] cur;
        cur = {bus.fsm_state == ST_GUARD, bus.sym_tick, bus.fq_ud, bus.grant_psk,
               bus.grant_costas, bus.pps_lost, bus.missed};
        for (int i = 0; i < 7; i++) begin
            if (cur[i] && !prv[i]) begin
                rise_c[i] = cyc;
                rise_i[i] = (i == EV_TICK) ? int'(bus.sym_index) : 0;
            end
            if (!cur[i] && prv[i]) begin
                check_ev(i, rise_c[i], cyc - rise_c[i], rise_i[i]);
            end
        end
        if (bus.grant_costas || bus.grant_psk || bus.fq_ud || bus.sym_tick) begin
            n_cmp++;
            if ((bus.grant_costas && bus.grant_psk) ||
                ((bus.fq_ud || bus.sym_tick) && !(bus.grant_costas || bus.grant_psk))) begin
                n_mis++;
                $display("FAIL invariant at cycle %0d: gc=%0b gp=%0b fq=%0b tick=%0b, required one grant covering strobes",
                         cyc, bus.grant_costas, bus.grant_psk, bus.fq_ud, bus.sym_tick);
            end
        end
        prv = cur;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pps_rise(output int t);
        @(posedge clk);
        #1;
        bus.pps = 1'b1;
        t = cyc;
    endtask

    task automatic pps_fall();
        tick(5);
        bus.pps       = 1'b0;
        bus.time_sync = 1'b0;
    endtask

    task automatic filler();
        int t;
        pps_rise(t);
        pps_fall();
        tick(20);
    endtask

    // Symbol k of a transmission starting at cycle s: fq_ud rises at
    // s + k*div for 4 cycles, sym_tick at s + k*div + div/2.
    task automatic exp_symbols(input int s, input int div, input int n);
        for (int k = 0; k < n; k++) begin
            exp_ev(EV_FQ, s + k * div, 4, 0);
            exp_ev(EV_TICK, s + k * div + div / 2, 1, k);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int t;
        int s;
        int ta;
        int lost_rise;
        bus.pps         = 1'b0;
        bus.time_sync   = 1'b0;
        bus.costas_txrq = 1'b0;
        bus.psk_txrq    = 1'b0;
        rst = 1'b1;
        tick(3);

        check_val("reset_grant_costas", int'(bus.grant_costas), 0);
        check_val("reset_grant_psk",    int'(bus.grant_psk), 0);
        check_val("reset_fq_ud",        int'(bus.fq_ud), 0);
        check_val("reset_sym_tick",     int'(bus.sym_tick), 0);
        check_val("reset_sym_index",    int'(bus.sym_index), 0);
        check_val("reset_sec_count",    int'(bus.sec_count), 0);
        check_val("reset_missed",       int'(bus.missed), 0);
        check_val("reset_pps_lost",     int'(bus.pps_lost), 0);
        check_val("reset_state",        int'(bus.fsm_state), 0);
        rst = 1'b0;
        tick(2);

        // time_sync second is a PSK slot with no PSK request: missed.
        bus.costas_txrq = 1'b1;
        bus.time_sync   = 1'b1;
        pps_rise(t);
        exp_ev(EV_MISSED, t + 4, 1, 0);
        pps_fall();
        tick(20);
        repeat (59) filler();
        check_val("sec_before_minute", int'(bus.sec_count), 59);

        // Second 60: Costas, 4 symbols of 100 cycles, grant 4 cycles after pps.
        pps_rise(t);
        s = t + 4;
        exp_symbols(s, 100, 4);
        exp_ev(EV_GC, s, 400, 0);
        exp_ev(EV_GUARD, s + 400, 10, 0);
        pps_fall();
        wait_until(s + 430);
        check_val("sec_at_costas", int'(bus.sec_count), 60);

        // Second 0 with both requests: PSK wins, 8 symbols of 20 cycles.
        bus.psk_txrq  = 1'b1;
        bus.time_sync = 1'b1;
        pps_rise(t);
        s = t + 4;
        exp_symbols(s, 20, 8);
        exp_ev(EV_GP, s, 160, 0);
        exp_ev(EV_GUARD, s + 160, 10, 0);
        pps_fall();
        wait_until(s + 200);
        check_val("sec_after_sync", int'(bus.sec_count), 0);

        // Minute slot without a Costas request.
        bus.costas_txrq = 1'b0;
        bus.psk_txrq    = 1'b0;
        repeat (59) filler();
        pps_rise(t);
        exp_ev(EV_MISSED, t + 4, 1, 0);
        pps_fall();
        tick(20);
        check_val("sec_missed_minute", int'(bus.sec_count), 60);

        // PSK request dropped in symbol 3: ends at that symbol's wrap.
        bus.psk_txrq  = 1'b1;
        bus.time_sync = 1'b1;
        pps_rise(ta);
        s = ta + 4;
        exp_symbols(s, 20, 4);
        exp_ev(EV_GP, s, 80, 0);
        exp_ev(EV_GUARD, s + 80, 10, 0);
        pps_fall();
        wait_until(s + 65);
        bus.psk_txrq = 1'b0;
        wait_until(s + 100);
        check_val("psk_drop_sym_index", int'(bus.sym_index), 0);

        // PPS withheld: the edge is acted on at ta+4, the flag follows
        // 1125 cycles later. The next slot edge is missed and clears it.
        lost_rise = ta + 4 + 1125;
        wait_until(ta + 1100);
        check_val("pps_lost_early", int'(bus.pps_lost), 0);
        wait_until(ta + 1200);
        check_val("pps_lost_set", int'(bus.pps_lost), 1);
        bus.psk_txrq  = 1'b1;
        bus.time_sync = 1'b1;
        pps_rise(t);
        exp_ev(EV_LOST, lost_rise, t + 4 - lost_rise, 0);
        exp_ev(EV_MISSED, t + 4, 1, 0);
        pps_fall();
        tick(20);
        check_val("pps_lost_cleared", int'(bus.pps_lost), 0);
        bus.psk_txrq = 1'b0;

        // Reset during Costas symbol 2.
        bus.costas_txrq = 1'b1;
        repeat (59) filler();
        pps_rise(t);
        s = t + 4;
        exp_symbols(s, 100, 2);
        exp_ev(EV_FQ, s + 200, 4, 0);
        exp_ev(EV_GC, s, 220, 0);
        pps_fall();
        wait_until(s + 220);
        rst = 1'b1;
        #1;
        check_val("rst_mid_grant_costas", int'(bus.grant_costas), 0);
        check_val("rst_mid_fq_ud",        int'(bus.fq_ud), 0);
        check_val("rst_mid_sym_index",    int'(bus.sym_index), 0);
        check_val("rst_mid_sec_count",    int'(bus.sec_count), 0);
        check_val("rst_mid_state",        int'(bus.fsm_state), 0);
        tick(3);
        rst = 1'b0;
        tick(2);
        filler();
        // Next slot is second 0 (PSK priority) with no PSK request.
        bus.time_sync = 1'b1;
        pps_rise(t);
        exp_ev(EV_MISSED, t + 4, 1, 0);
        pps_fall();
        tick(20);

        // Full frame without requests: nine Costas slots and the 599->0 wrap.
        bus.costas_txrq = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            pps_rise(t);
            if (k % 60 == 0) exp_ev(EV_MISSED, t + 4, 1, 0);
            pps_fall();
            tick(20);
            if (k == 599) check_val("sec_frame_end", int'(bus.sec_count), 599);
        end
        check_val("sec_wrapped", int'(bus.sec_count), 0);

        tick(20);
        check_val("expected_queue_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin : timeout
        #1000000;
        n_mis++;
        $display("FAIL timeout: got cycle %0d, required end of stimulus", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
